hamming_stream_decoder: RTL and testbench

//  Byte-serial SECDED decoder for the 16-bit extended-Hamming codewords that the core's
//  hgp/hel/hem program produces from 11-bit data. It accepts a codeword as two bytes
//  (LSB, then MSB) and corrects any single-bit error. It returns the 11-bit payload as
//  two bytes with error flags, and keeps saturating error statistics.

---
 rtl/hamming_stream_decoder.sv | 115 +++++++++++
 tb/tb_hamming_stream_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_stream_decoder.sv
// Byte-serial SECDED decoder for 16-bit extended-Hamming codewords carrying 11 data bits.
// Two bytes in (LSB first), one decode cycle, two bytes out with sec/ded flags and error statistics.
module hamming_stream_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [4:0]       err_pos,
    output logic [CNT_W-1:0] corrected_cnt,
    output logic [CNT_W-1:0] uncorrectable_cnt
);
    typedef enum logic [2:0] {
        RX_LO  = 3'd0,
        RX_MSB = 3'd1,
        DECODE = 3'd2,
        TX_LO  = 3'd3,
        TX_HI  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] cw_p0;
    logic [7:0]  hi_byte_p1;

    logic [3:0]  syn;
    logic        par;
    logic        sec;
    logic        ded;
    logic [10:0] data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Selects the data bit sitting at codeword position s; parity positions select nothing.
    function automatic logic [10:0] pos_mask(input logic [3:0] s);
        return {s == 4'd15, s == 4'd14, s == 4'd13, s == 4'd12, s == 4'd11,
                s == 4'd10, s == 4'd9,  s == 4'd7,  s == 4'd6,  s == 4'd5,
                s == 4'd3};
    endfunction

    always_comb begin
        syn[0] = ^(cw_p0 & 16'hAAAA);
        syn[1] = ^(cw_p0 & 16'hCCCC);
        syn[2] = ^(cw_p0 & 16'hF0F0);
        syn[3] = ^(cw_p0 & 16'hFF00);
        par    = ^cw_p0;
        sec    = par;
        ded    = !par && (syn != 4'd0);
        data   = {cw_p0[15:9], cw_p0[7:5], cw_p0[3]} ^ ({11{par}} & pos_mask(syn));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RX_LO;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            out_byte          <= 8'd0;
            err_pos           <= 5'd0;
            corrected_cnt     <= '0;
            uncorrectable_cnt <= '0;
        end else begin
            case (state)
                // p0: collect the two codeword bytes
                RX_LO: begin
                    if (in_valid) begin
                        cw_p0[7:0] <= in_byte;
                        state      <= RX_MSB;
                    end
                end
                RX_MSB: begin
                    if (in_valid) begin
                        cw_p0[15:8] <= in_byte;
                        in_ready    <= 1'b0;
                        state       <= DECODE;
                    end
                end
                // p1: register corrected payload, flags and statistics
                DECODE: begin
                    err_pos    <= {syn, par};
                    out_byte   <= data[7:0];
                    hi_byte_p1 <= {ded, sec, 3'b000, data[10:8]};
                    if (sec) corrected_cnt <= sat_inc(corrected_cnt);
                    if (ded) uncorrectable_cnt <= sat_inc(uncorrectable_cnt);
                    out_valid  <= 1'b1;
                    state      <= TX_LO;
                end
                // p2: present both result bytes, holding while the consumer stalls
                TX_LO: begin
                    if (out_ready) begin
                        out_byte <= hi_byte_p1;
                        state    <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= RX_LO;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= RX_LO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Scoreboard bench for hamming_stream_decoder: stimulus pushes expected bytes, a monitor pops
// and compares on every output handshake; expectations come from a positional codeword model.
module tb_hamming_stream_decoder;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_byte = 8'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_byte;
    logic [4:0]       err_pos;
    logic [CNT_W-1:0] corrected_cnt;
    logic [CNT_W-1:0] uncorrectable_cnt;

    hamming_stream_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .err_pos(err_pos), .corrected_cnt(corrected_cnt), .uncorrectable_cnt(uncorrectable_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         first;
        logic [4:0] ep;
        int         cc;
        int         uc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cc = 0;
    int   exp_uc = 0;
    int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        cw = '0;
        for (int j = 0; j < 11; j++) cw[DPOS[j]] = d[j];
        for (int b = 0; b < 4; b++) begin
            logic p;
            p = 1'b0;
            for (int i = 1; i < 16; i++) if (((i >> b) & 1) == 1) p = p ^ cw[i];
            cw[1 << b] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = cw[DPOS[j]];
        return d;
    endfunction

    // Syndrome as XOR of the indices of all set bits; overall parity as the popcount's LSB.
    task automatic ref_decode(input logic [15:0] cw, output logic [7:0] lo, output logic [7:0] hi,
                              output logic [4:0] ep, output int kind);
        int s, ones;
        logic [15:0] c;
        logic [10:0] d;
        s = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) if (cw[i]) begin s = s ^ i; ones++; end
        c = cw;
        kind = 0;
        if (ones % 2 == 1) begin c[s] = ~c[s]; kind = 1; end
        else if (s != 0) kind = 2;
        d  = extract(c);
        lo = d[7:0];
        hi = {kind == 2, kind == 1, 3'b000, d[10:8]};
        ep = {s[3:0], ones[0]};
    endtask

    task automatic push_word(input logic [7:0] lo, input logic [7:0] hi, input logic [4:0] ep,
                             input int kind);
        if (kind == 1 && exp_cc < CMAX) exp_cc++;
        if (kind == 2 && exp_uc < CMAX) exp_uc++;
        q.push_back('{lo, 1'b1, ep, exp_cc, exp_uc});
        q.push_back('{hi, 1'b0, ep, exp_cc, exp_uc});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        while (!in_ready && n < 300) begin n++; @(negedge clk); end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0, required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int g);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input int gap);
        send_byte(lo);
        idle(gap);
        send_byte(hi);
    endtask

    task automatic directed(input logic [15:0] cw, input int gap);
        logic [7:0] lo, hi;
        logic [4:0] ep;
        int kind;
        ref_decode(cw, lo, hi, ep, kind);
        push_word(lo, hi, ep, kind);
        send_word(cw[7:0], cw[15:8], gap);
    endtask

    task automatic random_word(input int nf, input int gap);
        logic [10:0] d, dexp;
        logic [15:0] cw;
        logic [4:0]  ep;
        int e1, e2, x;
        d  = 11'($urandom_range(0, 2047));
        cw = encode(d);
        e1 = $urandom_range(0, 15);
        e2 = (e1 + $urandom_range(1, 15)) % 16;
        x  = e1 ^ e2;
        if (nf >= 1) cw[e1] = ~cw[e1];
        if (nf == 2) cw[e2] = ~cw[e2];
        dexp = (nf == 2) ? extract(cw) : d;
        ep   = (nf == 0) ? 5'd0 : (nf == 1) ? {e1[3:0], 1'b1} : {x[3:0], 1'b0};
        push_word(dexp[7:0], {nf == 2, nf == 1, 3'b000, dexp[10:8]}, ep, nf);
        send_word(cw[7:0], cw[15:8], gap);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin n++; @(posedge clk); #1; end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        idle(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        exp_cc = 0;
        exp_uc = 0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        check("rst_corrected_cnt", 32'(corrected_cnt), 32'd0);
        check("rst_uncorrectable_cnt", 32'(uncorrectable_cnt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Consumer-side ready generator
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: one scoreboard entry per accepted output byte
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got byte 0x%0h, required no output", out_byte);
            end else begin
                e = q.pop_front();
                check(e.first ? "out_byte_lo" : "out_byte_hi", 32'(out_byte), 32'(e.b));
                if (e.first) begin
                    check("err_pos", 32'(err_pos), 32'(e.ep));
                    check("corrected_cnt", 32'(corrected_cnt), 32'(e.cc));
                    check("uncorrectable_cnt", 32'(uncorrectable_cnt), 32'(e.uc));
                end
            end
        end
    end

    initial begin
        int n;
        idle(1);
        do_reset();

        push_word(8'hA9, 8'h07, 5'h00, 0);
        send_word(8'h9C, 8'hF5, 0);
        push_word(8'h9C, 8'h40, 5'h1B, 1);
        send_word(8'hD1, 8'h32, 0);
        directed(16'h0440, 0);
        push_word(8'hA9, 8'h47, 5'h01, 1);
        send_word(8'h9D, 8'hF5, 0);
        push_word(8'hA9, 8'h07, 5'h00, 0);
        send_word(8'h9C, 8'hF5, 5);
        drain();

        // Latency and stall: consumer holds off while TX_LO is presented
        rdy_mode = 1;
        idle(1);
        push_word(8'hA9, 8'h07, 5'h00, 0);
        send_word(8'h9C, 8'hF5, 0);
        @(negedge clk);
        check("decode_out_valid", 32'(out_valid), 32'd0);
        check("decode_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_out_byte", 32'(out_byte), 32'hA9);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        drain();

        for (int w = 0; w < 60; w++) random_word($urandom_range(0, 2), $urandom_range(0, 3));
        drain();

        // Reset with only the LSB of a word accepted
        send_byte(8'hD1);
        do_reset();
        push_word(8'hA9, 8'h07, 5'h00, 0);
        send_word(8'h9C, 8'hF5, 0);
        drain();

        rdy_mode = 2;
        for (int w = 0; w < 260; w++) random_word(1, 0);
        drain();
        check("sat_corrected_cnt", 32'(corrected_cnt), 32'(CMAX));
        n = 0;
        check("sat_uncorrectable_cnt", 32'(uncorrectable_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end
endmodule
